// File: rtl/md_pkg.sv
// Shared types for the execute-stage multiply/divide unit.
// Op encoding, FSM states and op-class helpers.
package md_pkg;

  typedef enum logic [3:0] {
    MD_MULT  = 4'd0,
    MD_MULTU = 4'd1,
    MD_DIV   = 4'd2,
    MD_DIVU  = 4'd3,
    MD_MADD  = 4'd4,
    MD_MADDU = 4'd5,
    MD_MSUB  = 4'd6,
    MD_MSUBU = 4'd7,
    MD_MTHI  = 4'd8,
    MD_MTLO  = 4'd9
  } op_e;

  typedef enum logic [2:0] {
    S_IDLE,
    S_MUL_WAIT,
    S_DIV_RUN,
    S_DIV_FIX,
    S_DIV_WAIT
  } state_e;

  function automatic logic is_signed(op_e op);
    return op inside {MD_MULT, MD_DIV, MD_MADD, MD_MSUB};
  endfunction

  function automatic logic is_div(op_e op);
    return op inside {MD_DIV, MD_DIVU};
  endfunction

  function automatic logic is_mul(op_e op);
    return op inside {MD_MULT, MD_MULTU, MD_MADD,
                      MD_MADDU, MD_MSUB, MD_MSUBU};
  endfunction

endpackage

// File: rtl/md_divider.sv
// Iterative restoring divider, one quotient bit per cycle,
// followed by a single sign fix-up cycle.
module md_divider
  import md_pkg::*;
#(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         start,
  input  logic         flush,
  input  logic         sign,
  input  logic [W-1:0] dividend,
  input  logic [W-1:0] divisor,
  output logic [W-1:0] quotient,
  output logic [W-1:0] remainder,
  output logic         valid,
  output logic         dz
);

  localparam int IW = $clog2(W + 1);
  localparam logic [W-1:0] MIN = {1'b1, {(W-1){1'b0}}};

  logic          run;
  logic          fix;
  logic          neg_q;
  logic          neg_r;
  logic          ovf;
  logic [IW-1:0] cnt;
  logic [W-1:0]  q;
  logic [W-1:0]  r;
  logic [W-1:0]  dvs;
  logic [W-1:0]  num;
  logic [W:0]    rem_sh;
  logic [W:0]    trial;

  function automatic logic [W-1:0] mag(
    input logic         s,
    input logic [W-1:0] x
  );
    return (s && x[W-1]) ? -x : x;
  endfunction

  assign rem_sh    = {r, q[W-1]};
  assign trial     = rem_sh - {1'b0, dvs};
  assign quotient  = q;
  assign remainder = r;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      run   <= 1'b0;
      fix   <= 1'b0;
      valid <= 1'b0;
      dz    <= 1'b0;
      ovf   <= 1'b0;
      neg_q <= 1'b0;
      neg_r <= 1'b0;
      cnt   <= '0;
      q     <= '0;
      r     <= '0;
      dvs   <= '0;
      num   <= '0;
    end else if (flush) begin
      run   <= 1'b0;
      fix   <= 1'b0;
      valid <= 1'b0;
    end else if (start) begin
      q     <= mag(sign, dividend);
      r     <= '0;
      dvs   <= mag(sign, divisor);
      num   <= dividend;
      neg_q <= sign & (dividend[W-1] ^ divisor[W-1]);
      neg_r <= sign & dividend[W-1];
      dz    <= (divisor == '0);
      ovf   <= sign && (dividend == MIN) && (divisor == '1);
      cnt   <= IW'(W);
      run   <= 1'b1;
      fix   <= 1'b0;
      valid <= 1'b0;
    end else if (run) begin
      if (!trial[W]) begin
        r <= trial[W-1:0];
        q <= {q[W-2:0], 1'b1};
      end else begin
        r <= rem_sh[W-1:0];
        q <= {q[W-2:0], 1'b0};
      end
      cnt <= cnt - 1'b1;
      if (cnt == IW'(1)) begin
        run <= 1'b0;
        fix <= 1'b1;
      end
    end else if (fix) begin
      fix   <= 1'b0;
      valid <= 1'b1;
      // quotient on divide-by-zero is forced to all ones by the consumer
      unique case (1'b1)
        dz: begin
          r <= num;
        end
        ovf: begin
          q <= MIN;
          r <= '0;
        end
        default: begin
          q <= neg_q ? -q : q;
          r <= neg_r ? -r : r;
        end
      endcase
    end
  end

endmodule

// File: rtl/md_unit.sv
// Execute-stage multiply/divide unit with HI/LO registers,
// multiply-accumulate and fixed per-class busy latencies.
module md_unit
  import md_pkg::*;
#(
  parameter int W           = 32,
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 34
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         start,
  input  logic [3:0]   op,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         flush,
  output logic         busy,
  output logic         done,
  output logic [W-1:0] hi,
  output logic [W-1:0] lo
);

  localparam int MAXC =
    (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CW = $clog2(MAXC + 1);
  localparam logic [CW-1:0] MUL_N   = CW'(MULT_CYCLES);
  localparam logic [CW-1:0] DIV_N   = CW'(DIV_CYCLES);
  localparam logic [CW-1:0] RUN_END = CW'(DIV_CYCLES - W + 1);

  state_e          state;
  logic [CW-1:0]   cnt;
  logic [2*W-1:0]  prod;
  logic [2*W-1:0]  prod_n;
  logic [2*W-1:0]  ext_a;
  logic [2*W-1:0]  ext_b;
  logic [2*W-1:0]  acc_res;
  logic            acc_add;
  logic            acc_sub;
  op_e             op_d;
  logic            sgn;
  logic            accept;
  logic            div_start;
  logic [W-1:0]    div_q;
  logic [W-1:0]    div_r;
  logic            div_valid;
  logic            div_dz;

  assign op_d      = op_e'(op);
  assign sgn       = is_signed(op_d);
  assign accept    = start && (state == S_IDLE) && !flush;
  assign div_start = accept && is_div(op_d);

  assign ext_a  = sgn ? {{W{a[W-1]}}, a} : {{W{1'b0}}, a};
  assign ext_b  = sgn ? {{W{b[W-1]}}, b} : {{W{1'b0}}, b};
  assign prod_n = ext_a * ext_b;

  assign acc_res = acc_sub ? ({hi, lo} - prod) :
                   acc_add ? ({hi, lo} + prod) : prod;

  md_divider #(.W(W)) u_div (
    .clk       (clk),
    .reset     (reset),
    .start     (div_start),
    .flush     (flush),
    .sign      (sgn),
    .dividend  (a),
    .divisor   (b),
    .quotient  (div_q),
    .remainder (div_r),
    .valid     (div_valid),
    .dz        (div_dz)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state   <= S_IDLE;
      cnt     <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
      hi      <= '0;
      lo      <= '0;
      prod    <= '0;
      acc_add <= 1'b0;
      acc_sub <= 1'b0;
    end else begin
      done <= 1'b0;
      if (flush) begin
        state <= S_IDLE;
        cnt   <= '0;
        busy  <= 1'b0;
      end else begin
        unique case (state)
          S_IDLE: begin
            if (start) begin
              unique case (1'b1)
                op_d == MD_MTHI: hi <= a;
                op_d == MD_MTLO: lo <= a;
                is_mul(op_d): begin
                  prod    <= prod_n;
                  acc_add <= op_d inside {MD_MADD, MD_MADDU};
                  acc_sub <= op_d inside {MD_MSUB, MD_MSUBU};
                  cnt     <= MUL_N;
                  busy    <= 1'b1;
                  state   <= S_MUL_WAIT;
                end
                is_div(op_d): begin
                  cnt   <= DIV_N;
                  busy  <= 1'b1;
                  state <= S_DIV_RUN;
                end
                default: ;
              endcase
            end
          end
          S_MUL_WAIT: begin
            if (cnt == CW'(1)) begin
              {hi, lo} <= acc_res;
              done     <= 1'b1;
              busy     <= 1'b0;
              cnt      <= '0;
              state    <= S_IDLE;
            end else begin
              cnt <= cnt - 1'b1;
            end
          end
          S_DIV_RUN: begin
            cnt <= cnt - 1'b1;
            if (cnt == RUN_END) state <= S_DIV_FIX;
          end
          S_DIV_FIX: begin
            cnt   <= cnt - 1'b1;
            state <= S_DIV_WAIT;
          end
          S_DIV_WAIT: begin
            // divider result is held stable until the latency expires
            if (cnt == CW'(1) && div_valid) begin
              hi    <= div_r;
              lo    <= div_dz ? '1 : div_q;
              done  <= 1'b1;
              busy  <= 1'b0;
              cnt   <= '0;
              state <= S_IDLE;
            end else if (cnt != CW'(1)) begin
              cnt <= cnt - 1'b1;
            end
          end
          default: state <= S_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_md_unit.sv
// Directed bench for md_unit with hand-computed results.
// Checks latency, HI/LO results, flush, reset and issue rules.
module tb_md_unit;
  import md_pkg::*;

  localparam int W  = 32;
  localparam int MC = 5;
  localparam int DC = 34;

  logic         clk   = 1'b0;
  logic         reset = 1'b0;
  logic         start = 1'b0;
  logic         flush = 1'b0;
  logic [3:0]   op    = 4'd0;
  logic [W-1:0] a     = '0;
  logic [W-1:0] b     = '0;
  logic         busy;
  logic         done;
  logic [W-1:0] hi;
  logic [W-1:0] lo;

  int n_assert = 0;
  int n_fail   = 0;
  int cyc      = 0;

  md_unit #(
    .W           (W),
    .MULT_CYCLES (MC),
    .DIV_CYCLES  (DC)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .start (start),
    .op    (op),
    .a     (a),
    .b     (b),
    .flush (flush),
    .busy  (busy),
    .done  (done),
    .hi    (hi),
    .lo    (lo)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(
    input string       tag,
    input logic [63:0] obs,
    input logic [63:0] exp
  );
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic issue(
    input op_e          o,
    input logic [W-1:0] x,
    input logic [W-1:0] y
  );
    op    = o;
    a     = x;
    b     = y;
    start = 1'b1;
    tick;
    start = 1'b0;
  endtask

  task automatic wait_idle(output int n);
    n = 0;
    while (busy && n < 200) begin
      n++;
      tick;
    end
  endtask

  task automatic run_op(
    input string        tag,
    input op_e          o,
    input logic [W-1:0] x,
    input logic [W-1:0] y,
    input int           exp_n
  );
    int n;
    issue(o, x, y);
    wait_idle(n);
    chk({tag, " cycles"}, 64'(n), 64'(exp_n));
    chk({tag, " done"}, 64'(done), 64'd1);
  endtask

  initial begin
    int n;
    int dn;
    int t0;

    reset = 1'b0;
    repeat (2) tick;
    chk("rst busy", 64'(busy), 64'd0);
    chk("rst done", 64'(done), 64'd0);
    chk("rst hilo", {hi, lo}, 64'd0);
    reset = 1'b1;
    tick;

    run_op("mult", MD_MULT, 32'hFFFF_FFFE, 32'd3, MC);
    chk("mult hilo", {hi, lo}, 64'hFFFF_FFFF_FFFF_FFFA);
    tick;
    chk("mult done once", 64'(done), 64'd0);

    run_op("multu", MD_MULTU, 32'hFFFF_FFFE, 32'd3, MC);
    chk("multu hilo", {hi, lo}, 64'h0000_0002_FFFF_FFFA);

    issue(MD_MTHI, 32'h12, 32'd0);
    chk("mthi busy", 64'(busy), 64'd0);
    chk("mthi done", 64'(done), 64'd0);
    issue(MD_MTLO, 32'd0, 32'd0);
    chk("mthi/mtlo hilo", {hi, lo}, 64'h0000_0012_0000_0000);

    run_op("maddu", MD_MADDU, 32'hFFFF_FFFF, 32'd2, MC);
    chk("maddu hilo", {hi, lo}, 64'h0000_0013_FFFF_FFFE);

    run_op("msub", MD_MSUB, 32'd3, 32'hFFFF_FFFF, MC);
    chk("msub hilo", {hi, lo}, 64'h0000_0014_0000_0001);

    run_op("div", MD_DIV, 32'hFFFF_FFF9, 32'd2, DC);
    chk("div -7/2", {hi, lo}, 64'hFFFF_FFFF_FFFF_FFFD);

    run_op("div2", MD_DIV, 32'd7, 32'hFFFF_FFFE, DC);
    chk("div 7/-2", {hi, lo}, 64'h0000_0001_FFFF_FFFD);

    run_op("divu", MD_DIVU, 32'd100, 32'd7, DC);
    chk("divu 100/7", {hi, lo}, 64'h0000_0002_0000_000E);

    run_op("divu0", MD_DIVU, 32'd5, 32'd0, DC);
    chk("divu 5/0", {hi, lo}, 64'h0000_0005_FFFF_FFFF);

    run_op("div0", MD_DIV, 32'hFFFF_FFFB, 32'd0, DC);
    chk("div -5/0", {hi, lo}, 64'hFFFF_FFFB_FFFF_FFFF);

    run_op("divov", MD_DIV, 32'h8000_0000, 32'hFFFF_FFFF, DC);
    chk("div min/-1", {hi, lo}, 64'h0000_0000_8000_0000);

    issue(MD_DIV, 32'd100, 32'd7);
    repeat (9) tick;
    flush = 1'b1;
    tick;
    flush = 1'b0;
    chk("flush busy", 64'(busy), 64'd0);
    chk("flush hilo", {hi, lo}, 64'h0000_0000_8000_0000);
    dn = 0;
    repeat (40) begin
      if (done) dn++;
      tick;
    end
    chk("flush no done", 64'(dn), 64'd0);
    chk("flush hilo late", {hi, lo}, 64'h0000_0000_8000_0000);

    run_op("div after flush", MD_DIVU, 32'd9, 32'd4, DC);
    chk("divu 9/4", {hi, lo}, 64'h0000_0001_0000_0002);

    issue(MD_MULT, 32'd2, 32'd3);
    tick;
    op    = MD_MTHI;
    a     = 32'hDEAD;
    start = 1'b1;
    tick;
    start = 1'b0;
    wait_idle(n);
    chk("busy start cycles", 64'(n + 2), 64'(MC));
    chk("busy start done", 64'(done), 64'd1);
    chk("busy start hilo", {hi, lo}, 64'h0000_0000_0000_0006);

    op    = MD_MTHI;
    a     = 32'hBEEF;
    start = 1'b1;
    flush = 1'b1;
    tick;
    chk("flush+mthi hi", {32'd0, hi}, 64'd0);
    op = MD_MULT;
    tick;
    start = 1'b0;
    flush = 1'b0;
    chk("flush+mult busy", 64'(busy), 64'd0);

    t0 = cyc;
    issue(MD_MULT, 32'd4, 32'd5);
    wait_idle(n);
    chk("b2b first done", 64'(done), 64'd1);
    chk("b2b first hilo", {hi, lo}, 64'd20);
    op    = MD_MULTU;
    a     = 32'd6;
    b     = 32'd7;
    start = 1'b1;
    tick;
    start = 1'b0;
    chk("b2b second busy", 64'(busy), 64'd1);
    wait_idle(n);
    chk("b2b second done", 64'(done), 64'd1);
    chk("b2b latency", 64'(cyc - t0), 64'(2 * (MC + 1)));
    chk("b2b second hilo", {hi, lo}, 64'd42);

    issue(MD_MULT, 32'hFFFF_FFFE, 32'd3);
    tick;
    #3;
    reset = 1'b0;
    #1;
    chk("async rst busy", 64'(busy), 64'd0);
    chk("async rst done", 64'(done), 64'd0);
    chk("async rst hilo", {hi, lo}, 64'd0);
    tick;
    reset = 1'b1;
    dn = 0;
    repeat (10) begin
      if (done) dn++;
      tick;
    end
    chk("rst no done", 64'(dn), 64'd0);
    chk("rst hilo late", {hi, lo}, 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/md_unit.md
# md_unit

Parametrised multi-cycle multiply/divide unit with HI/LO registers. It sits in the execute stage beside the ALU. The hazard unit samples `busy` to stall the decode stage on any MD-class instruction. It extends the fixed-latency start/busy scheme with multiply-accumulate, selectable latencies, an iterative divider, flush, and a defined divide-by-zero result.

## Interface
- `W`, default 32: operand width, and the width of HI and LO.
- `MULT_CYCLES`, default 5: busy cycles for the multiply family; must be ≥1.
- `DIV_CYCLES`, default 34: busy cycles for the divide family; must be ≥ W+2.
- `clk`  in  1  single clock; all state changes on the rising edge.
- `reset`  in  1  asynchronous, active-low; clears all state.
- `start`  in  1  issue request; `op`, `a`, `b` are valid in the same cycle.
- `op`  in  4  operation code, encoded in `md_pkg`.
- `a`  in  W  rs operand.
- `b`  in  W  rt operand.
- `flush`  in  1  cancel any in-flight operation; HI/LO keep their old values.
- `busy`  out  1  operation in flight; the hazard unit must stall.
- `done`  out  1  one-cycle pulse on the cycle HI/LO take a multiply/divide result.
- `hi`  out  W  HI register; MFHI reads it directly.
- `lo`  out  W  LO register; MFLO reads it directly.

## Operation
- Ops: MULT, MULTU, DIV, DIVU, MADD, MADDU, MSUB, MSUBU, MTHI, MTLO.
- A `start` is accepted only when `busy`=0 and `flush`=0.
  - A `start` while `busy`=1 is ignored.
  - `flush` wins over a simultaneous `start`.
- MTHI/MTLO:
  - HI (or LO) ← `a` at the accepting edge.
  - No busy period and no `done` pulse.
- MULT/MULTU:
  - The 2W-bit product (signed or unsigned) is captured into a pending register at the accepting edge.
  - At completion, {HI,LO} ← product.
- MADD/MSUB (signed and unsigned variants):
  - The product is captured at the accepting edge.
  - At completion, {HI,LO} ← {HI,LO} ± product, modulo 2^(2W).
- DIV/DIVU use the iterative restoring divider, one quotient bit per cycle:
  - Signed operations divide magnitudes, then apply a sign fix-up: the quotient is negative when the operand signs differ; the remainder takes the dividend's sign.
  - Remainder goes to HI, quotient to LO.
  - After the W iterations and the fix-up cycle, the result is held until DIV_CYCLES have elapsed.
- Divide by zero: LO ← all ones, HI ← `a`.
- Signed overflow (MIN ÷ −1): LO ← MIN, HI ← 0.
- FSM states and transitions:
  - IDLE → MUL_WAIT, or IDLE → DIV_RUN → DIV_FIX → DIV_WAIT.
  - Each state exits to IDLE on completion.
  - `flush` sends any state to IDLE with no HI/LO write.

## Timing
- Reset values: `busy`=0, `done`=0, `hi`=0, `lo`=0, FSM=IDLE, counters=0.
- Reset asserted mid-operation aborts the operation immediately; the result is lost.
- Accepting edge at cycle T:
  - `busy`=1 for cycles T+1 … T+N, where N = MULT_CYCLES or DIV_CYCLES.
  - HI/LO update at the edge ending cycle T+N.
  - `busy`=0 and `done`=1 in cycle T+N+1.
- A new `start` in cycle T+N+1 is accepted (back-to-back issue).
- `flush` in cycle F (busy): `busy`=0 from F+1, and `done` never pulses for that operation.
- `hi`/`lo` are plain registers, with no bypass of an in-flight result.
- The hazard unit must stall MFHI/MFLO/MTHI/MTLO and new MD ops while `busy`=1, and also in the issuing cycle.

## Structure
- `md_pkg` holds:
  - the op encoding enum (MD_MULT=0 … MD_MTLO=9);
  - FSM state typedef;
  - an `is_signed(op)` helper;
  - a `is_div(op)` helper.
- Sub-module `md_divider`:
  - ports: W-parametrised `start`, `sign`, `dividend`, `divisor`, `quotient`, `remainder`, `valid`, `dz`;
  - implements DIV_RUN/DIV_FIX and the divide-by-zero and overflow rules;
  - flush/reset aborts it.
- Top-level `md_unit`: FSM, latency counter, product/accumulate path, HI/LO registers.

## Test plan
- MULT 0xFFFF_FFFE × 3 (W=32, MULT_CYCLES=5): `busy` for 5 cycles, then HI=0xFFFF_FFFF, LO=0xFFFF_FFFA, and `done` pulses once.
- MULTU with the same operands: HI=0x0000_0002, LO=0xFFFF_FFFA.
- MTHI 0x12 then MADDU 0xFFFF_FFFF × 2: {HI,LO} ends as 0x0000_0013_FFFF_FFFE.
- DIV −7 ÷ 2 (DIV_CYCLES=34): `busy` for 34 cycles, then LO=0xFFFF_FFFD, HI=0xFFFF_FFFF.
- DIVU 5 ÷ 0: LO=0xFFFF_FFFF, HI=5.
- DIV 0x8000_0000 ÷ −1: LO=0x8000_0000, HI=0.
- Flush and reset:
  - `flush` on cycle 10 of a DIV: `busy`=0 next cycle, HI/LO unchanged, no `done`.
  - `reset` low mid-MULT: all outputs 0 asynchronously.
- Issue rules:
  - `start` while busy is ignored.
  - `start` together with `flush` is ignored.
  - Back-to-back MULTs complete 2×(MULT_CYCLES+1) cycles after the first issue.
